demux4_sched: RTL and testbench

DEMUX4_SCHED -- requirements
Module: demux4_sched

---
 rtl/demux4_sched.sv | 117 +++++++++++
 tb/tb_demux4_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_sched.sv
// demux4_sched: single-word 1-to-4 demultiplexer with round-robin or addressed dispatch and timeouts
module demux4_sched #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  logic             mode,
  input  logic [3:0]       ch_en,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             busy,
  output logic             err,
  output logic [15:0]      xfer_cnt,
  output logic [7:0]       drop_cnt
);
  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pay_q, pay_d;
  logic [1:0]       sel_q, sel_d, ptr_q, ptr_d, pick;
  logic [7:0]       wcnt_q, wcnt_d, drop_q, drop_d, drop_inc;
  logic [15:0]      xfer_q, xfer_d;
  logic             mode_q, mode_d, err_q, err_d, timeout;
  assign in_ready  = rst_n & e & (state_q == IDLE);
  assign y         = pay_q;
  assign out_valid = (state_q == SEND) ? 4'b0001 << sel_q : 4'b0000;
  assign busy      = state_q != IDLE;
  assign err       = err_q;
  assign xfer_cnt  = xfer_q;
  assign drop_cnt  = drop_q;
  assign timeout   = wcnt_q == 8'(TIMEOUT - 1);
  assign drop_inc  = drop_q + 8'(drop_q != 8'hff);
  // first enabled channel at or after the rotation pointer; lower offsets override higher ones
  always_comb begin
    pick = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (ch_en[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
  end
  // next-state, capture, counters and err pulse
  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    wcnt_d  = wcnt_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    xfer_d  = xfer_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        pay_d   = x;
        sel_d   = s;
        state_d = ARB;
      end
      ARB: if (mode) begin
        if (ch_en[sel_q]) begin
          state_d = SEND;
          wcnt_d  = '0;
          mode_d  = 1'b1;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
          drop_d  = drop_inc;
        end
      end else if (|ch_en) begin
        sel_d   = pick;
        state_d = SEND;
        wcnt_d  = '0;
        mode_d  = 1'b0;
      end
      SEND: if (out_ready[sel_q]) begin
        state_d = IDLE;
        xfer_d  = xfer_q + 16'd1;
        ptr_d   = mode_q ? ptr_q : sel_q + 2'd1;
      end else if (timeout) begin
        state_d = mode_q ? IDLE : ARB;
        ptr_d   = mode_q ? ptr_q : sel_q + 2'd1;
        err_d   = mode_q;
        drop_d  = mode_q ? drop_inc : drop_q;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pay_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      xfer_q  <= xfer_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_demux4_sched.sv
// tb_demux4_sched: directed scenarios plus random traffic checked against a transaction-level model
module tb_demux4_sched;
  localparam int W = 8;
  localparam int T = 16;
  logic         clk = 0, rst_n = 0, e = 0, mode = 0, in_valid = 0;
  logic [3:0]   ch_en = 0, out_ready = 0;
  logic [W-1:0] x = 0;
  logic [1:0]   s = 0;
  logic         in_ready, busy, err;
  logic [W-1:0] y;
  logic [3:0]   out_valid;
  logic [15:0]  xfer_cnt;
  logic [7:0]   drop_cnt;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  demux4_sched #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .e(e), .mode(mode), .ch_en(ch_en), .x(x), .s(s),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .err(err), .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  // transaction-level model: a held word is either waiting for a channel or being shown
  bit           held, pres, m_mode, m_err;
  int           dest, ptr, shown;
  logic [W-1:0] data;
  logic [15:0]  m_xfer;
  logic [7:0]   m_drop;
  task automatic model_drop();
    held = 0;
    pres = 0;
    m_err = 1;
    if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      held = 0; pres = 0; m_mode = 0; m_err = 0;
      dest = 0; ptr = 0; shown = 0; data = 0; m_xfer = 0; m_drop = 0;
    end else begin
      m_err = 0;
      if (!held) begin
        if (in_valid && e) begin
          held = 1;
          data = x;
          dest = int'(s);
        end
      end else if (!pres) begin
        if (mode) begin
          if (ch_en[dest]) begin pres = 1; shown = 0; m_mode = 1; end
          else model_drop();
        end else if (ch_en != 0) begin
          for (int k = 0; k < 4; k++)
            if (ch_en[(ptr + k) % 4]) begin dest = (ptr + k) % 4; break; end
          pres = 1; shown = 0; m_mode = 0;
        end
      end else begin
        shown++;
        if (out_ready[dest]) begin
          held = 0; pres = 0;
          m_xfer = m_xfer + 16'd1;
          if (!m_mode) ptr = (dest + 1) % 4;
        end else if (shown == T) begin
          if (m_mode) model_drop();
          else begin ptr = (dest + 1) % 4; pres = 0; end
        end
      end
    end
  end
  // every-cycle comparison against the model
  always @(negedge clk) if (chk_on) begin
    logic [3:0] exp_ov;
    logic       exp_rdy;
    exp_ov  = pres ? 4'(1 << dest) : 4'b0;
    exp_rdy = rst_n && e && !held;
    tests++;
    if (in_ready !== exp_rdy || out_valid !== exp_ov || y !== data || busy !== held ||
        err !== m_err || xfer_cnt !== m_xfer || drop_cnt !== m_drop) begin
      fails++;
      $display("FAIL model t=%0t rdy %b/%b ov %b/%b y %h/%h busy %b/%b err %b/%b xfer %0d/%0d drop %0d/%0d",
        $time, in_ready, exp_rdy, out_valid, exp_ov, y, data, busy, held, err, m_err,
        xfer_cnt, m_xfer, drop_cnt, m_drop);
    end
  end
  // delivery and occupancy monitor for the literal checks
  int del_ch[$];
  int ov0_cycles = 0, ov3_cycles = 0, err_cycles = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (out_valid[k] && out_ready[k]) del_ch.push_back(k);
    if (out_valid[0]) ov0_cycles++;
    if (out_valid[3]) ov3_cycles++;
    if (err) err_cycles++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    del_ch.delete();
    ov0_cycles = 0; ov3_cycles = 0; err_cycles = 0;
  endtask
  task automatic put(input logic [W-1:0] d, input logic [1:0] dst);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL put_wait got in_ready 0 want 1");
    end
    x = d; s = dst; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle got busy 1 want 0");
    end
    #2;
  endtask
  initial begin
    e = 1;
    @(posedge clk);
    #1 chk_on = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    // round robin over all four channels with latency
    do_reset();
    mode = 0; ch_en = 4'b1111; out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      put(8'hA0 + 8'(k), 2'd0);
      @(negedge clk); chk("rr_arb_ov", out_valid, 0);
      @(negedge clk); chk("rr_ov", out_valid, 32'(1 << k)); chk("rr_y", y, 32'hA0 + k);
    end
    wait_idle(50);
    chk("rr_xfer", xfer_cnt, 4);
    // sparse mask rotation, then pointer position
    do_reset();
    ch_en = 4'b1010;
    for (int k = 0; k < 3; k++) put(8'h10 + 8'(k), 2'd0);
    wait_idle(50);
    chk("sparse_n", del_ch.size(), 3);
    if (del_ch.size() == 3) begin
      chk("sparse_0", del_ch[0], 1); chk("sparse_1", del_ch[1], 3); chk("sparse_2", del_ch[2], 1);
    end
    ch_en = 4'b1111;
    del_ch.delete();
    put(8'h55, 2'd0);
    wait_idle(50);
    chk("ptr_end", del_ch.size() == 1 ? del_ch[0] : -1, 2);
    // addressed dispatch to a disabled channel
    do_reset();
    mode = 1; ch_en = 4'b1011;
    put(8'h77, 2'd2);
    @(negedge clk); chk("addr_arb_err", err, 0);
    @(negedge clk);
    chk("addr_err", err, 1); chk("addr_ov", out_valid, 0);
    chk("addr_rdy", in_ready, 1); chk("addr_drop", drop_cnt, 1);
    @(negedge clk); chk("addr_err_end", err, 0);
    // round-robin timeout retry on the next enabled channel
    do_reset();
    mode = 0; ch_en = 4'b0011; out_ready = 4'b0010;
    put(8'h3C, 2'd0);
    wait_idle(100);
    chk("to_ov0", ov0_cycles, 16);
    chk("to_ch", del_ch.size() == 1 ? del_ch[0] : -1, 1);
    chk("to_xfer", xfer_cnt, 1); chk("to_drop", drop_cnt, 0);
    // addressed timeout drops, saturating counter
    do_reset();
    mode = 1; ch_en = 4'b1111; out_ready = 4'b0000;
    put(8'h99, 2'd3);
    wait_idle(100);
    chk("ato_ov3", ov3_cycles, 16); chk("ato_err", err_cycles, 1); chk("ato_drop", drop_cnt, 1);
    for (int k = 0; k < 299; k++) put(8'(k), 2'd3);
    wait_idle(100);
    chk("sat_drop", drop_cnt, 255);
    // reset in the middle of SEND
    do_reset();
    mode = 0; out_ready = 4'b1111;
    put(8'h11, 2'd0);
    wait_idle(50);
    chk("pre_rst_xfer", xfer_cnt, 1);
    out_ready = 4'b0000;
    put(8'h22, 2'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_send", out_valid != 0, 1);
    err_cycles = 0;
    do_reset();
    @(negedge clk);
    chk("mr_ov", out_valid, 0); chk("mr_busy", busy, 0);
    chk("mr_xfer", xfer_cnt, 0); chk("mr_drop", drop_cnt, 0); chk("mr_err", err, 0);
    // random traffic against the model
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom % 300) != 0;
      e         = ($urandom % 8) != 0;
      mode      = ($urandom % 2) != 0;
      ch_en     = ($urandom % 8 == 0) ? 4'b0 : 4'($urandom);
      x         = W'($urandom);
      s         = 2'($urandom);
      in_valid  = ($urandom % 2) != 0;
      out_ready = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
    end
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
